uart_bus_ctrl: RTL and testbench

Memory-mapped bus-side controller for the `uart` core. It owns the other end of the core's byte interface:
- drives `load`/`d` and watches `txbusy` to transmit;
- captures `q` on `bytercvd` to receive;
- generates the `bitxce` strobe from a programmable divisor.

CPU writes and reads bytes through small FIFOs, so software never polls the core cycle-by-cycle. It sits between the SoC peripheral bus and one `uart` instance.

---
 rtl/uart_bus_ctrl_pkg.sv | 25 ++
 rtl/uart_bus_ctrl_fifo.sv | 50 +++++
 rtl/uart_bus_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_ctrl_pkg.sv
// rtl/uart_bus_ctrl_pkg.sv - register map, STATUS bit positions and shared types for uart_bus_ctrl
package uart_bus_ctrl_pkg;

  // Word offsets on the peripheral bus
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_BUSY    = 5;

  // Value returned by a DATA read when nothing has been received
  localparam logic [31:0] RDATA_EMPTY = 32'hFFFF_FFFF;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/uart_bus_ctrl_fifo.sv
// rtl/uart_bus_ctrl_fifo.sv - synchronous 8-bit FIFO, depth 2**AW, extra pointer bit for full/empty
module uart_bus_ctrl_fifo
  import uart_bus_ctrl_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign head  = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers; storage is not reset since empty pointers hide stale data
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// rtl/uart_bus_ctrl.sv - bus-side uart controller; UART_BUS_CTRL_RXFIFO_EN selects RX FIFO over a holding register
module uart_bus_ctrl
  import uart_bus_ctrl_pkg::*;
#(
  parameter int          FIFO_AW   = 2,
  parameter logic [15:0] DIV_RESET = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        bitxce,
  output logic        uart_load,
  output logic [7:0]  uart_d,
  input  logic        uart_txbusy,
  input  logic        uart_bytercvd,
  input  logic [7:0]  uart_q
);

  bus_state_e  state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_we_q, req_we_d;
  logic [1:0]  req_addr_q, req_addr_d;
  logic [15:0] req_wdata_q, req_wdata_d;
  logic        req_pop_q, req_pop_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovr_q, ovr_d;
  logic        load_q, load_d;
  logic [7:0]  d_q, d_d;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_head;
  logic        rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic        ack_wr, div_wr, ovr_clr, ovr_set;
  logic [31:0] status_word;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:16];

  // Register side effects happen in the ACK cycle, after read data was captured
  assign ack_wr  = (state_q == BUS_ACK) && req_we_q;
  assign tx_push = ack_wr && (req_addr_q == ADDR_DATA);
  assign div_wr  = ack_wr && (req_addr_q == ADDR_DIV);
  assign ovr_clr = ack_wr && (req_addr_q == ADDR_STATUS) && req_wdata_q[ST_RX_OVERRUN];
  assign rx_pop  = (state_q == BUS_ACK) && req_pop_q;
  assign ovr_set = uart_bytercvd && rx_full && !rx_pop;

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign uart_load = load_q;
  assign uart_d    = d_q;
  assign bitxce    = !reset && (cnt_q == 16'd0);

  uart_bus_ctrl_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (req_wdata_q[7:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

`ifdef UART_BUS_CTRL_RXFIFO_EN
  uart_bus_ctrl_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (uart_bytercvd),
    .pop   (rx_pop),
    .din   (uart_q),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );
`else
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_hold_q, rx_hold_d;

  assign rx_full  = rx_valid_q;
  assign rx_empty = !rx_valid_q;
  assign rx_head  = rx_hold_q;

  // Single-entry receive buffer: a new byte lands only if the slot is free or being read out
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_hold_d  = rx_hold_q;
    if (rx_pop) begin
      rx_valid_d = 1'b0;
    end
    if (uart_bytercvd && (!rx_valid_q || rx_pop)) begin
      rx_valid_d = 1'b1;
      rx_hold_d  = uart_q;
    end
  end

  // Holding register state
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_hold_q  <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_hold_q  <= rx_hold_d;
    end
  end
`endif

  // STATUS word assembled from live FIFO flags
  always_comb begin
    status_word                = '0;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_TX_EMPTY]   = tx_empty;
    status_word[ST_RX_EMPTY]   = rx_empty;
    status_word[ST_RX_FULL]    = rx_full;
    status_word[ST_RX_OVERRUN] = ovr_q;
    status_word[ST_TX_BUSY]    = uart_txbusy;
  end

  // Bus FSM: accept in IDLE (DATA writes wait for TX space), acknowledge for exactly one cycle
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_pop_d   = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (sel && !(we && (addr == ADDR_DATA) && tx_full)) begin
          state_d     = BUS_ACK;
          ready_d     = 1'b1;
          req_we_d    = we;
          req_addr_d  = addr;
          req_wdata_d = wdata[15:0];
          rdata_d     = '0;
          if (!we) begin
            case (addr)
              ADDR_DATA: begin
                if (rx_empty) begin
                  rdata_d = RDATA_EMPTY;
                end else begin
                  rdata_d   = {24'b0, rx_head};
                  req_pop_d = 1'b1;
                end
              end
              ADDR_STATUS: rdata_d = status_word;
              ADDR_DIV:    rdata_d = {16'b0, div_q};
              default:     rdata_d = '0;
            endcase
          end
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  // Divisor, baud counter, overrun flag and TX drain handshake
  always_comb begin
    div_d = div_wr ? req_wdata_q : div_q;
    if (div_wr) begin
      cnt_d = '0;
    end else if (cnt_q == 16'd0) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end

    ovr_d = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;

    // load_q guard covers the cycle before the core reports busy
    load_d = !tx_empty && !uart_txbusy && !load_q;
    d_d    = load_d ? tx_head : d_q;
    tx_pop = load_q;
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BUS_IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_pop_q   <= 1'b0;
      div_q       <= DIV_RESET;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      load_q      <= 1'b0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_pop_q   <= req_pop_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      load_q      <= load_d;
      d_q         <= d_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb/tb_uart_bus_ctrl.sv - randomized self-checking bench for uart_bus_ctrl with queue-based reference model
module tb_uart_bus_ctrl;

  localparam int          AW       = 2;
  localparam int          TX_DEPTH = 1 << AW;
`ifdef UART_BUS_CTRL_RXFIFO_EN
  localparam int          RX_DEPTH = 1 << AW;
`else
  localparam int          RX_DEPTH = 1;
`endif
  localparam logic [15:0] DIV_RST  = 16'd2;

  logic        clk, reset, sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ready, bitxce, uart_load, uart_txbusy, uart_bytercvd;
  logic [7:0]  uart_d, uart_q;

  uart_bus_ctrl #(.FIFO_AW(AW), .DIV_RESET(DIV_RST)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .bitxce(bitxce), .uart_load(uart_load),
    .uart_d(uart_d), .uart_txbusy(uart_txbusy), .uart_bytercvd(uart_bytercvd),
    .uart_q(uart_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: bytes written but not yet sent, bytes received but not yet read
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          ovr;
  logic [15:0] div_m;
  bit          hold_busy;
  int          n_loads;

  function automatic logic [31:0] exp_status(input bit busy);
    logic [31:0] s;
    s    = '0;
    s[0] = (txq.size() == TX_DEPTH);
    s[1] = (txq.size() == 0);
    s[2] = (rxq.size() == 0);
    s[3] = (rxq.size() == RX_DEPTH);
    s[4] = ovr;
    s[5] = busy;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: each load starts a frame, busy rises the cycle after and lasts a few cycles
  initial begin
    int  busy_cnt;
    bit  kick, busy_seen;
    logic [8:0] exp_d;
    busy_cnt = 0; kick = 0; busy_seen = 1; n_loads = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0; kick = 0; busy_seen = 1;
      end else begin
        if (uart_txbusy) busy_seen = 1;
        if (kick) begin
          busy_cnt = $urandom_range(3, 8);
          kick = 0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        if (uart_load) begin
          n_loads++;
          check("load_separated_by_busy", 32'(busy_seen), 32'd1);
          busy_seen = 0;
          exp_d = (txq.size() != 0) ? {1'b0, txq.pop_front()} : 9'h100;
          check("uart_d", {24'b0, uart_d}, {23'b0, exp_d});
          kick = 1;
        end
      end
      uart_txbusy = hold_busy || (busy_cnt > 0);
    end
  end

  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    sel = 1'b1; we = w; addr = a; wdata = wd; lat = 0; rd = '0;
    while (lat < 200) begin
      tick();
      lat++;
      if (ready) break;
    end
    check("bus_ready", {31'b0, ready}, 32'd1);
    rd = rdata;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    int lat;
    bus(1'b1, a, wd, rd, lat);
    if (a == 2'd1 && wd[4]) ovr = 0;
    if (a == 2'd2) div_m = wd[15:0];
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input bit busy);
    logic [31:0] got, exp;
    int lat;
    case (a)
      2'd1:    exp = exp_status(busy);
      2'd2:    exp = {16'b0, div_m};
      2'd3:    exp = '0;
      default: exp = 32'h0;
    endcase
    if (a == 2'd0) exp = (rxq.size() != 0) ? {24'b0, rxq.pop_front()} : 32'hFFFF_FFFF;
    bus(1'b0, a, 32'h0, got, lat);
    check(tag, got, exp);
  endtask

  task automatic tx_write(input logic [7:0] v);
    txq.push_back(v);
    wr(2'd0, {$urandom, v} >> 0);
  endtask

  task automatic rx_inject(input logic [7:0] v);
    uart_q = v; uart_bytercvd = 1'b1;
    tick();
    uart_bytercvd = 1'b0;
    if (rxq.size() < RX_DEPTH) rxq.push_back(v);
    else ovr = 1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while ((txq.size() != 0 || uart_txbusy || uart_load) && n < 600) begin
      tick();
      n++;
    end
    check("tx_drained", txq.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int lat, l0, j, n;
    logic [7:0] v;

    sel = 0; we = 0; addr = 0; wdata = 0; reset = 1; uart_bytercvd = 0; uart_q = 0;
    hold_busy = 0; uart_txbusy = 0; ovr = 0; div_m = DIV_RST;
    repeat (3) tick();
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_load", {31'b0, uart_load}, 32'd0);
    check("rst_uart_d", {24'b0, uart_d}, 32'd0);
    check("rst_bitxce", {31'b0, bitxce}, 32'd0);

    reset = 0;
    #1;
    check("bitxce_first", {31'b0, bitxce}, 32'd1);
    for (int k = 1; k < 7; k++) begin
      tick();
      check("bitxce_reset_div", {31'b0, bitxce}, {31'b0, (k % (DIV_RST + 1)) == 0});
    end
    rd_chk("div_reset_val", 2'd2, 1'b0);

    // Baud strobe with DIV=3 then DIV=0
    tick();
    bus(1'b1, 2'd2, 32'hABCD_0003, got, lat);
    div_m = 16'd3;
    check("bus_latency", lat, 32'd1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("bitxce_div3", {31'b0, bitxce}, {31'b0, (k % 4) == 0});
    end
    rd_chk("div_readback", 2'd2, 1'b0);
    wr(2'd2, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("bitxce_div0", {31'b0, bitxce}, 32'd1);
    end

    // TX latency from idle
    tick();
    tx_write(8'h33);
    j = 0;
    while (j < 10) begin
      tick();
      j++;
      if (uart_load) break;
    end
    check("tx_latency", j, 32'd2);
    wait_tx_idle();

    // TX burst with busy held: fifth write stalls until a slot drains
    hold_busy = 1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) tx_write(8'h41 + 8'(i));
    txq.push_back(8'h45);
    sel = 1; we = 1; addr = 2'd0; wdata = 32'h45;
    n = 0;
    repeat (6) begin
      tick();
      if (ready) n++;
    end
    check("tx_full_stall", n, 32'd0);
    l0 = n_loads;
    hold_busy = 0;
    j = 0;
    while (!ready && j < 50) begin
      tick();
      j++;
    end
    check("tx_fifth_ack", {31'b0, ready}, 32'd1);
    sel = 0; we = 0;
    check("tx_one_load_before_ack", n_loads - l0, 32'd1);
    wait_tx_idle();

    // RX single byte and empty read
    rx_inject(8'h5A);
    rd_chk("rx_data", 2'd0, 1'b0);
    rd_chk("rx_empty_read", 2'd0, 1'b0);

    // Overrun and clear
    for (int i = 0; i <= RX_DEPTH; i++) rx_inject(8'h10 + 8'(i));
    rd_chk("ovr_status", 2'd1, 1'b0);
    for (int i = 0; i < RX_DEPTH; i++) rd_chk("ovr_data_order", 2'd0, 1'b0);
    wr(2'd1, 32'h10);
    rd_chk("ovr_cleared", 2'd1, 1'b0);

    // Simultaneous push and pop while RX is full
    for (int i = 0; i < RX_DEPTH; i++) rx_inject(8'($urandom));
    tick();
    sel = 1; we = 0; addr = 2'd0;
    j = 0;
    while (!ready && j < 10) begin
      tick();
      j++;
    end
    check("simul_ready", {31'b0, ready}, 32'd1);
    got = rdata;
    v = 8'($urandom);
    uart_q = v; uart_bytercvd = 1; sel = 0;
    check("simul_rdata", got, {24'b0, rxq.pop_front()});
    tick();
    uart_bytercvd = 0;
    rxq.push_back(v);
    rd_chk("simul_status", 2'd1, 1'b0);
    while (rxq.size() != 0) rd_chk("simul_drain", 2'd0, 1'b0);

    // Randomized traffic with the core held busy
    hold_busy = 1;
    repeat (2) tick();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0, 1: rx_inject(8'($urandom));
        2: rd_chk("rnd_data", 2'd0, 1'b1);
        3: rd_chk("rnd_status", 2'd1, 1'b1);
        4: wr(2'd1, $urandom);
        5: if ($urandom_range(0, 1) == 0) begin
             wr(2'd2, $urandom);
             rd_chk("rnd_div", 2'd2, 1'b1);
           end else begin
             rd_chk("rnd_reserved", 2'd3, 1'b1);
           end
        default: if (txq.size() < TX_DEPTH) tx_write(8'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end
    hold_busy = 0;
    wait_tx_idle();
    while (rxq.size() != 0) rd_chk("rnd_drain", 2'd0, 1'b0);

    // Reset in the middle of traffic
    wr(2'd2, 32'd5);
    hold_busy = 1;
    repeat (2) tick();
    tx_write(8'hA1);
    tx_write(8'hA2);
    rx_inject(8'hB1);
    rx_inject(8'hB2);
    reset = 1;
    hold_busy = 0;
    repeat (2) tick();
    txq.delete(); rxq.delete(); ovr = 0; div_m = DIV_RST;
    reset = 0;
    #1;
    check("rst_mid_bitxce_first", {31'b0, bitxce}, 32'd1);
    for (int k = 1; k < 9; k++) begin
      tick();
      check("rst_mid_bitxce", {31'b0, bitxce}, {31'b0, (k % (DIV_RST + 1)) == 0});
      check("rst_mid_no_load", {31'b0, uart_load}, 32'd0);
    end
    bus(1'b0, 2'd1, 32'h0, got, lat);
    check("rst_mid_status", got, 32'h0000_0006);
    rd_chk("rst_mid_div", 2'd2, 1'b0);
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
